// File: rtl/axi_w_order_sched_m3.sv
// W-channel ordering scheduler: grants W to masters in AW-acceptance order, one burst at a time.
// Latency: W grant appears the cycle after the queuing AW handshake; zero-bubble between bursts.
module axi_w_order_sched_m3 #(
    parameter  int NUM   = 3,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic [NUM-1:0] AWGRANT,
    input  logic [NUM-1:0] AWVALID,
    input  logic           S_AWREADY,
    output logic           AW_FULL,
    input  logic [NUM-1:0] WVALID,
    input  logic [NUM-1:0] WLAST,
    input  logic           S_WREADY,
    output logic [NUM-1:0] WGRANT,
    output logic [CW-1:0]  WQ_COUNT,
    output logic           ERR_OVF,
    output logic           ERR_ONEHOT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);
    localparam logic [NUM-1:0] VEC_ONE = NUM'(1);

    typedef enum logic {W_IDLE, W_BURST} state_t;

    state_t         state_q, state_d;
    logic [NUM-1:0] fifo_q [DEPTH];
    logic [NUM-1:0] fifo_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [NUM-1:0] wgrant_q, wgrant_d;
    logic           aw_full_q, aw_full_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_onehot_q, err_onehot_d;

    logic aw_fire, aw_onehot, push, pop;

    always_comb begin
        aw_fire   = (|(AWGRANT & AWVALID)) & S_AWREADY;
        aw_onehot = (AWGRANT != '0) && ((AWGRANT & (AWGRANT - VEC_ONE)) == '0);
        // Full is judged on registered state, so a same-cycle pop never frees room.
        push      = aw_fire & ~aw_full_q & aw_onehot;
        pop       = (|(wgrant_q & WVALID & WLAST)) & S_WREADY;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (push) begin
            fifo_d[wr_ptr_q] = AWGRANT;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            W_IDLE:  if (push) state_d = W_BURST;
            W_BURST: if (pop && (count_q == CNT_ONE) && !push) state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase

        // Grant is the post-edge head, so the pushed entry is visible only next cycle.
        wgrant_d     = (state_d == W_BURST) ? fifo_d[rd_ptr_d] : '0;
        aw_full_d    = (count_d == CNT_MAX);
        err_ovf_d    = err_ovf_q | (aw_fire & aw_full_q);
        err_onehot_d = err_onehot_q | (aw_fire & ~aw_onehot);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wgrant_q     <= '0;
            aw_full_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_onehot_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wgrant_q     <= wgrant_d;
            aw_full_q    <= aw_full_d;
            err_ovf_q    <= err_ovf_d;
            err_onehot_q <= err_onehot_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge ACLK) begin
        fifo_q <= fifo_d;
    end

    assign WGRANT     = wgrant_q;
    assign AW_FULL    = aw_full_q;
    assign WQ_COUNT   = count_q;
    assign ERR_OVF    = err_ovf_q;
    assign ERR_ONEHOT = err_onehot_q;

endmodule

// File: tb/tb_axi_w_order_sched_m3.sv
// Bench for axi_w_order_sched_m3: queue-based reference of AW order, per-cycle output checks.
module tb_axi_w_order_sched_m3;

    localparam int NUM   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           ACLK = 1'b0;
    logic           ARESETn;
    logic [NUM-1:0] AWGRANT, AWVALID, WVALID, WLAST, WGRANT;
    logic           S_AWREADY, S_WREADY, AW_FULL, ERR_OVF, ERR_ONEHOT;
    logic [CW-1:0]  WQ_COUNT;

    axi_w_order_sched_m3 #(.NUM(NUM), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWGRANT(AWGRANT), .AWVALID(AWVALID), .S_AWREADY(S_AWREADY), .AW_FULL(AW_FULL),
        .WVALID(WVALID), .WLAST(WLAST), .S_WREADY(S_WREADY), .WGRANT(WGRANT),
        .WQ_COUNT(WQ_COUNT), .ERR_OVF(ERR_OVF), .ERR_ONEHOT(ERR_ONEHOT)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: queue of expected grants in AW order, plus sticky error flags.
    logic [NUM-1:0] exp_q [$];
    logic           m_ovf = 1'b0;
    logic           m_oh  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [NUM-1:0] m_head();
        return (exp_q.size() != 0) ? exp_q[0] : '0;
    endfunction

    function automatic bit is_onehot(input logic [NUM-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Called at a negedge with inputs set: advance model, clock once, compare everything.
    task automatic cyc();
        logic [NUM-1:0] mg;
        bit awf, full, pop;
        mg   = m_head();
        awf  = (|(AWGRANT & AWVALID)) && S_AWREADY;
        full = (exp_q.size() == DEPTH);
        pop  = (|(mg & WVALID & WLAST)) && S_WREADY;
        if (!ARESETn) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_oh  = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (awf && !full && is_onehot(AWGRANT)) exp_q.push_back(AWGRANT);
            if (awf && full) m_ovf = 1'b1;
            if (awf && !is_onehot(AWGRANT)) m_oh = 1'b1;
        end
        @(posedge ACLK);
        @(negedge ACLK);
        check("wgrant",  32'(WGRANT),     32'(m_head()));
        check("count",   32'(WQ_COUNT),   32'(exp_q.size()));
        check("aw_full", 32'(AW_FULL),    32'(exp_q.size() == DEPTH));
        check("err_ovf", 32'(ERR_OVF),    32'(m_ovf));
        check("err_oh",  32'(ERR_ONEHOT), 32'(m_oh));
    endtask

    task automatic idle_inputs();
        AWGRANT = '0; AWVALID = '0; S_AWREADY = 1'b1;
        WVALID  = '0; WLAST   = '0; S_WREADY  = 1'b1;
    endtask

    task automatic aw(input int m);
        idle_inputs();
        AWGRANT = NUM'(1) << m;
        AWVALID = NUM'(1) << m;
        cyc();
        idle_inputs();
    endtask

    // One W beat on the currently expected head master.
    task automatic wbeat(input bit last, input bit rdy);
        idle_inputs();
        WVALID   = m_head();
        WLAST    = last ? m_head() : '0;
        S_WREADY = rdy;
        cyc();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        ARESETn = 1'b0;
        @(negedge ACLK);
        cyc();
        ARESETn = 1'b1;

        // Idle with random W noise on ungranted masters.
        for (int i = 0; i < 10; i++) begin
            WVALID = NUM'($urandom_range(0, 7));
            WLAST  = NUM'($urandom_range(0, 7));
            cyc();
        end
        idle_inputs();
        check("t1_grant", 32'(WGRANT), 32'h0);

        // Single AW from M1, 4-beat burst with a 3-cycle stall on beat 2.
        aw(1);
        check("t2_grant_next", 32'(WGRANT), 32'h2);
        wbeat(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) wbeat(1'b0, 1'b0);
        check("t2_grant_stall", 32'(WGRANT), 32'h2);
        wbeat(1'b0, 1'b1);
        wbeat(1'b0, 1'b1);
        check("t2_grant_prelast", 32'(WGRANT), 32'h2);
        wbeat(1'b1, 1'b1);
        check("t2_grant_done", 32'(WGRANT), 32'h0);

        // Order M2, M0, M1 then single-beat bursts.
        aw(2); aw(0); aw(1);
        check("t3_g0", 32'(WGRANT), 32'h4);
        wbeat(1'b1, 1'b1);
        check("t3_g1", 32'(WGRANT), 32'h1);
        wbeat(1'b1, 1'b1);
        check("t3_g2", 32'(WGRANT), 32'h2);
        wbeat(1'b1, 1'b1);
        check("t3_g3", 32'(WGRANT), 32'h0);

        // Fill to DEPTH, overflow attempt, pop one.
        aw(0); aw(1); aw(2); aw(0);
        check("t4_full", 32'(AW_FULL), 32'h1);
        check("t4_cnt",  32'(WQ_COUNT), 32'h4);
        aw(2);
        check("t4_ovf",  32'(ERR_OVF), 32'h1);
        check("t4_cnt2", 32'(WQ_COUNT), 32'h4);
        // Pop and push in the same cycle while full: push must be refused.
        idle_inputs();
        WVALID = m_head(); WLAST = m_head();
        AWGRANT = 3'b010; AWVALID = 3'b010;
        cyc();
        idle_inputs();
        check("t4_notfull", 32'(AW_FULL), 32'h0);
        check("t4_cnt3",    32'(WQ_COUNT), 32'h3);
        for (int i = 0; i < 3; i++) wbeat(1'b1, 1'b1);
        check("t4_drained", 32'(WQ_COUNT), 32'h0);

        // count==1: WLAST handshake concurrent with new AW from M0.
        aw(2);
        WVALID = 3'b100; WLAST = 3'b100;
        AWGRANT = 3'b001; AWVALID = 3'b001;
        cyc();
        idle_inputs();
        check("t5_cnt",   32'(WQ_COUNT), 32'h1);
        check("t5_grant", 32'(WGRANT),   32'h1);
        wbeat(1'b1, 1'b1);

        // Non-one-hot AW grant, and AW with AWREADY low (no fire).
        AWGRANT = 3'b011; AWVALID = 3'b011;
        cyc();
        check("t_onehot", 32'(ERR_ONEHOT), 32'h1);
        AWGRANT = 3'b001; AWVALID = 3'b001; S_AWREADY = 1'b0;
        cyc();
        idle_inputs();
        check("t_noready", 32'(WQ_COUNT), 32'h0);

        // Reset mid-burst with three entries queued.
        aw(0); aw(1); aw(2);
        wbeat(1'b0, 1'b1);
        check("t6_pre", 32'(WQ_COUNT), 32'h3);
        ARESETn = 1'b0;
        WVALID = 3'b001;
        cyc();
        ARESETn = 1'b1;
        idle_inputs();
        check("t6_grant", 32'(WGRANT), 32'h0);
        check("t6_cnt",   32'(WQ_COUNT), 32'h0);
        check("t6_errs",  32'({ERR_OVF, ERR_ONEHOT}), 32'h0);

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            logic [NUM-1:0] hd;
            hd = m_head();
            AWGRANT   = ($urandom_range(0, 9) == 0) ? NUM'($urandom_range(0, 7))
                                                    : NUM'(1) << $urandom_range(0, NUM - 1);
            AWVALID   = ($urandom_range(0, 2) != 0) ? AWGRANT : '0;
            S_AWREADY = ($urandom_range(0, 3) != 0);
            WVALID    = NUM'($urandom_range(0, 7)) | (($urandom_range(0, 1) != 0) ? hd : '0);
            WLAST     = NUM'($urandom_range(0, 7));
            S_WREADY  = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
